// File: rtl/cpu_run_ctrl.sv
// Run controller for the 10-bit CPU core: turns a host start pulse into a core reset
// window, then gates execution (free-run / single-step) with watchdog, abort and counters.
module cpu_run_ctrl #(
    parameter int CNT_W      = 16,
    parameter int PC_W       = 8,
    parameter int RST_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             abort,
    input  logic [CNT_W-1:0] timeout_limit,
    input  logic             core_halt,
    input  logic             core_retire,
    input  logic [PC_W-1:0]  core_pc,
    output logic             core_rst,
    output logic             core_en,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic             aborted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] inst_count,
    output logic [PC_W-1:0]  final_pc
);
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d, inst_q, inst_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              to_q, to_d, ab_q, ab_d;
    logic              rst_q, en_q, busy_q, done_q;
    logic [CNT_W:0]    cyc_inc;

    // Extra bit so a saturated counter can never alias onto a timeout limit.
    assign cyc_inc = {1'b0, cyc_q} + {{CNT_W{1'b0}}, 1'b1};

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        cyc_d     = cyc_q;
        inst_d    = inst_q;
        pc_d      = pc_q;
        to_d      = to_q;
        ab_d      = ab_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RESET;
                    rst_cnt_d = '0;
                    cyc_d     = '0;
                    inst_d    = '0;
                    pc_d      = '0;
                    to_d      = 1'b0;
                    ab_d      = 1'b0;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RC_LAST) state_d = step_mode ? S_PAUSE : S_RUN;
                else                      rst_cnt_d = rst_cnt_q + RC_W'(1);
            end
            S_RUN: begin
                if (~&cyc_q)                 cyc_d  = cyc_q + CNT_W'(1);
                if (core_retire && ~&inst_q) inst_d = inst_q + CNT_W'(1);
                if (core_halt) begin
                    state_d = S_DONE;
                    pc_d    = core_pc;
                end else if (abort) begin
                    state_d = S_DONE;
                    ab_d    = 1'b1;
                end else if (timeout_limit != '0 && cyc_inc == {1'b0, timeout_limit}) begin
                    state_d = S_DONE;
                    to_d    = 1'b1;
                end else if (step_mode) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_d = S_DONE;
                    ab_d    = 1'b1;
                end else if (!step_mode || step) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            rst_cnt_q <= '0;
            cyc_q     <= '0;
            inst_q    <= '0;
            pc_q      <= '0;
            to_q      <= 1'b0;
            ab_q      <= 1'b0;
            rst_q     <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            cyc_q     <= cyc_d;
            inst_q    <= inst_d;
            pc_q      <= pc_d;
            to_q      <= to_d;
            ab_q      <= ab_d;
            rst_q     <= (state_d == S_RESET);
            en_q      <= (state_d == S_RUN);
            busy_q    <= (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_PAUSE);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign core_rst    = rst_q;
    assign core_en     = en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timed_out   = to_q;
    assign aborted     = ab_q;
    assign cycle_count = cyc_q;
    assign inst_count  = inst_q;
    assign final_pc    = pc_q;
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run controller that sequences the 10-bit CPU core (TopLevel) through a program execution.
- Converts a host start pulse into a core reset window, then gates core execution through a clock enable.
- Supports free-run and single-step modes, watchdog timeout and abort.
- Counts enabled cycles and retired instructions, and captures the final PC on halt. Sits between the host/debug interface and the core.

Parameters:
- CNT_W, 16: width of cycle_count, inst_count and timeout_limit.
- PC_W, 8: width of core_pc and final_pc.
- RST_CYCLES, 2: number of cycles core_rst is held high (minimum 1).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- step_mode  in  1  1 = single-step, 0 = free-run; sampled every cycle.
- step  in  1  one-cycle pulse; advances one core cycle while paused.
- abort  in  1  terminates an active run.
- timeout_limit  in  CNT_W  maximum enabled cycles per run; 0 disables the watchdog.
- core_halt  in  1  core halt flag.
- core_retire  in  1  high for one cycle per completed instruction.
- core_pc  in  PC_W  current core PC.
- core_rst  out  1  active-high reset to the core (the core's start input).
- core_en  out  1  core clock enable.
- busy  out  1  high in RESET, RUN and PAUSE.
- done  out  1  high in DONE.
- timed_out  out  1  run ended by the watchdog.
- aborted  out  1  run ended by abort.
- cycle_count  out  CNT_W  enabled cycles in the current or last run.
- inst_count  out  CNT_W  instructions retired in the current or last run.
- final_pc  out  PC_W  core_pc captured when halt is sampled.

Behaviour:
- All outputs are registered.
- Reset (RESET_N low, asynchronous): state IDLE; every output is 0.
- States: IDLE, RESET, RUN, PAUSE, DONE.
- core_en = (state == RUN).
- busy = state is RESET, RUN or PAUSE.
- done = (state == DONE).
- IDLE:
  - start -> RESET.
  - On the same edge, clear cycle_count, inst_count, final_pc, timed_out and aborted.
- RESET:
  - core_rst is 1 for exactly RST_CYCLES cycles, beginning the cycle after start is sampled.
  - Then go to PAUSE if step_mode = 1, else RUN.
  - abort is ignored in RESET.
- RUN (core_en = 1), evaluated each cycle:
  - cycle_count += 1, saturating at all-ones.
  - core_retire = 1: inst_count += 1, saturating.
  - Termination priority: core_halt > abort > timeout.
  - core_halt = 1 -> DONE; final_pc <= core_pc.
  - abort = 1 -> DONE; aborted <= 1.
  - timeout_limit != 0 and cycle_count + 1 == timeout_limit -> DONE; timed_out <= 1. A run therefore has at most timeout_limit enabled cycles.
  - Otherwise, step_mode = 1 -> PAUSE. Each RUN visit in step mode lasts exactly one cycle.
  - The terminating cycle is itself counted, and a retire on that cycle is counted.
- PAUSE (core_en = 0):
  - abort -> DONE; aborted <= 1.
  - Else step_mode = 0 -> RUN.
  - Else step -> RUN for one cycle.
  - Counters hold.
- DONE:
  - Counters, flags and final_pc hold.
  - start -> RESET, clearing them as in IDLE.
- Ignored inputs:
  - start is ignored in RESET, RUN and PAUSE.
  - core_halt and core_retire are ignored outside RUN.
  - step is ignored outside PAUSE.
- A simultaneous halt and abort in RUN ends with aborted = 0 and final_pc captured.
- Asynchronous reset mid-run returns to IDLE immediately. core_en and core_rst drop without waiting for a clock edge.

Test Plan:
- Free run, RST_CYCLES=2, timeout_limit=0: pulse start. Required: core_rst high for 2 cycles, then core_en high. Retire 7 times, then halt on the 10th enabled cycle with core_pc=8'h2A. Required: done=1, busy=0, cycle_count=10, inst_count=7, final_pc=8'h2A, timed_out=0, aborted=0.
- Watchdog: timeout_limit=5, halt never asserted. Required: exactly 5 core_en cycles, then done=1, timed_out=1, cycle_count=5.
- Single step: step_mode=1, start, then 3 step pulses spaced 4 cycles apart. Required: exactly 3 single-cycle core_en pulses, cycle_count=3. Then drop step_mode: continuous run resumes the next cycle.
- Abort and priority:
  - abort in PAUSE -> aborted=1, cycle_count unchanged.
  - abort in RUN together with core_halt and core_pc=8'h10 -> aborted=0, final_pc=8'h10.
- Restart and reset:
  - start in DONE clears the counters and repeats the RESET window.
  - RESET_N low mid-RUN -> core_en, busy and all counters read 0 before the next CLK edge.
- Saturation, with CNT_W=4 and timeout_limit=0: run 20 enabled cycles with retire held high. Required: cycle_count=4'hF, inst_count=4'hF, no wrap.
